// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder plus an iterative multiply/divide unit owning the HI/LO registers.
// Multiply and divide each take one iteration per cycle on operand magnitudes, sign-fixed at the end.
module alu_ctrl_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic [3:0]         ALUCtrl_o,
  output logic               stall_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               mdu_done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [ALUOP_W-1:0] OpRType = ALUOP_W'(2);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              is_div_q, signed_q;
  logic [WIDTH-1:0]  a_q, b_q, mag_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              done_q;

  logic              is_rtype, is_mdu, is_mfhilo, accept, sign_op;
  logic [WIDTH-1:0]  abs1, abs2;
  logic [WIDTH:0]    sum, rem_sh;
  logic              ge;
  logic [WIDTH-1:0]  diff, nxt_hi, nxt_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  assign is_rtype  = (ALUOp_i == OpRType);
  assign is_mdu    = is_rtype && (funct_i[5:2] == 4'b0110);
  assign is_mfhilo = is_rtype && ((funct_i == 6'b010000) || (funct_i == 6'b010010));
  assign accept    = valid_i && is_mdu && (state_q != StBusy);
  assign stall_o   = valid_i && (state_q == StBusy) && (is_mdu || is_mfhilo);

  // mult/div are the even codes, multu/divu the odd ones
  assign sign_op = ~funct_i[0];
  assign abs1    = (sign_op && src1_i[WIDTH-1]) ? -src1_i : src1_i;
  assign abs2    = (sign_op && src2_i[WIDTH-1]) ? -src2_i : src2_i;

  always_comb begin
    ALUCtrl_o = 4'b0000;
    case (ALUOp_i)
      ALUOP_W'(0): ALUCtrl_o = 4'b0010;
      ALUOP_W'(1): ALUCtrl_o = 4'b0110;
      ALUOP_W'(2): begin
        case (funct_i)
          6'b100000: ALUCtrl_o = 4'b0010;
          6'b100010: ALUCtrl_o = 4'b0110;
          6'b100100: ALUCtrl_o = 4'b0000;
          6'b100101: ALUCtrl_o = 4'b0001;
          6'b101010: ALUCtrl_o = 4'b0111;
          6'b100111: ALUCtrl_o = 4'b1100;
          6'b010000: ALUCtrl_o = 4'b1110;
          6'b010010: ALUCtrl_o = 4'b1111;
          default:   ALUCtrl_o = 4'b0000;
        endcase
      end
      ALUOP_W'(3): ALUCtrl_o = 4'b0010;
      ALUOP_W'(4): ALUCtrl_o = 4'b0111;
      ALUOP_W'(5): ALUCtrl_o = 4'b0000;
      ALUOP_W'(6): ALUCtrl_o = 4'b0001;
      default:     ALUCtrl_o = 4'b0000;
    endcase
  end

  // One shift-add or restoring-divide step on {acc_hi_q, acc_lo_q}
  always_comb begin
    sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : '0);
    rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, mag_q});
    diff   = rem_sh[WIDTH-1:0] - mag_q;
    if (is_div_q) begin
      nxt_hi = ge ? diff : rem_sh[WIDTH-1:0];
      nxt_lo = {acc_lo_q[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {nxt_hi, nxt_lo};
    res_hi = nxt_hi;
    res_lo = nxt_lo;
    if (!is_div_q) begin
      if (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) prod = -prod;
      {res_hi, res_lo} = prod;
    end else if (b_q == '0) begin
      res_lo = '1;
      res_hi = a_q;
    end else begin
      if (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) res_lo = -nxt_lo;
      if (signed_q && a_q[WIDTH-1]) res_hi = -nxt_hi;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mag_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q  <= StBusy;
            cnt_q    <= CntW'(WIDTH - 1);
            is_div_q <= funct_i[1];
            signed_q <= sign_op;
            a_q      <= src1_i;
            b_q      <= src2_i;
            acc_hi_q <= '0;
            acc_lo_q <= funct_i[1] ? abs1 : abs2;
            mag_q    <= funct_i[1] ? abs2 : abs1;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          acc_hi_q <= nxt_hi;
          acc_lo_q <= nxt_lo;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign mdu_done_o = done_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: issued MDU ops queue expected HI/LO and completion cycle,
// a monitor pops on every done pulse.
module tb_alu_ctrl_mdu;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [5:0]  funct;
  logic [2:0]  aluop;
  logic [31:0] src1, src2;
  logic [3:0]  alu_ctrl;
  logic        stall, done;
  logic [31:0] hi, lo;

  alu_ctrl_mdu #(.WIDTH(W), .ALUOP_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
    .src1_i(src1), .src2_i(src2), .ALUCtrl_o(alu_ctrl), .stall_o(stall),
    .hi_o(hi), .lo_o(lo), .mdu_done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
    string       name;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo;
  } mvec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 want 0", cyc);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    valid = 1'b1; aluop = op; funct = f; src1 = a; src2 = b;
  endtask

  task automatic idle_in();
    valid = 1'b0; aluop = 3'b000; funct = 6'h20;
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                      input int at);
    exp_t e;
    e.hi = h; e.lo = l; e.at = at; e.name = name;
    sbq.push_back(e);
  endtask

  // Presents an MDU op for one edge (the accept edge); acc is the cycle count after that edge.
  task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                       input bit do_push, output int acc);
    drive(3'b010, f, a, b);
    @(posedge clk); #1;
    acc = cyc;
    idle_in();
    if (do_push) push(name, h, l, acc + W);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3 * W && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [12:0] cv [23];
  mvec_t mv [11];
  int acc, acc2;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cv = '{{3'd0, 6'h20, 4'h2}, {3'd1, 6'h20, 4'h6}, {3'd3, 6'h20, 4'h2}, {3'd4, 6'h20, 4'h7},
           {3'd5, 6'h20, 4'h0}, {3'd6, 6'h20, 4'h1}, {3'd7, 6'h20, 4'h0}, {3'd5, 6'h27, 4'h0},
           {3'd0, 6'h2A, 4'h2}, {3'd2, 6'h20, 4'h2}, {3'd2, 6'h22, 4'h6}, {3'd2, 6'h24, 4'h0},
           {3'd2, 6'h25, 4'h1}, {3'd2, 6'h2A, 4'h7}, {3'd2, 6'h27, 4'hC}, {3'd2, 6'h10, 4'hE},
           {3'd2, 6'h12, 4'hF}, {3'd2, 6'h18, 4'h0}, {3'd2, 6'h19, 4'h0}, {3'd2, 6'h1A, 4'h0},
           {3'd2, 6'h1B, 4'h0}, {3'd2, 6'h00, 4'h0}, {3'd2, 6'h3F, 4'h0}};
    mv[0]  = {6'h18, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[1]  = {6'h19, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'hFFFFFFFD};
    mv[2]  = {6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[3]  = {6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    mv[4]  = {6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    mv[5]  = {6'h1A, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    mv[6]  = {6'h19, 32'h00003039, 32'h000002A6, 32'h00000000, 32'h007FB6F6};
    mv[7]  = {6'h1B, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    mv[8]  = {6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    mv[9]  = {6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    mv[10] = {6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    rst = 1'b1; src1 = '0; src2 = '0;
    drive(3'b010, 6'h1A, 32'd9, 32'd3);  // reset must win over an MDU op
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    idle_in();
    rst = 1'b0;

    valid = 1'b0;
    for (int i = 0; i < 23; i++) begin
      aluop = cv[i][12:10]; funct = cv[i][9:4];
      #1;
      check($sformatf("aluctrl_op%0d_f%h", aluop, funct), 64'(alu_ctrl), 64'(cv[i][3:0]));
    end
    idle_in();
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      issue($sformatf("mdu%0d", i), mv[i].f, mv[i].a, mv[i].b, mv[i].hi, mv[i].lo, 1'b1, acc);
      wait_drain();
    end

    // Non-MDU op in IDLE: no stall, HI/LO untouched
    drive(3'b010, 6'h20, 32'd1, 32'd2);
    #1;
    check("add_idle_stall", 64'(stall), 64'h0);
    @(posedge clk); #1;
    idle_in();
    check("add_idle_hi", 64'(hi), 64'hFFFFFFFE);
    check("add_idle_lo", 64'(lo), 64'h00000001);

    // mflo five cycles after a mult accept stalls until the DONE cycle
    issue("mflo_mult", 6'h18, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, acc);
    drive(3'b010, 6'h20, 32'd1, 32'd1);
    @(negedge clk);
    check("add_busy_stall", 64'(stall), 64'h0);
    idle_in();
    while (cyc < acc + 5) @(posedge clk);
    #1;
    drive(3'b010, 6'h12, 32'd0, 32'd0);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check("mflo_ctrl", 64'(alu_ctrl), 64'hF);
      check($sformatf("mflo_stall_c%0d", cyc - acc), 64'(stall), 64'(cyc < acc + W));
      if (cyc >= acc + W) break;
    end
    check("mflo_lo_at_done", 64'(lo), 64'd42);
    idle_in();
    wait_drain();

    // div held behind a busy mult: stalled, then accepted in the DONE cycle
    issue("b2b_mult", 6'h18, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, acc);
    drive(3'b010, 6'h1A, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check($sformatf("b2b_stall_c%0d", cyc - acc), 64'(stall), 64'(cyc < acc + W));
      if (cyc >= acc + W) break;
    end
    check("b2b_done_cycle", 64'(done), 64'h1);
    push("b2b_div", 32'hFFFFFFFF, 32'hFFFFFFFD, acc + 2 * W + 1);
    @(posedge clk); #1;
    idle_in();
    wait_drain();

    // Reset ten cycles into a div aborts it; a new mult is accepted right away
    issue("rst_div", 6'h1B, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    drive(3'b010, 6'h10, 32'd0, 32'd0);
    #1;
    check("abort_mfhi_stall", 64'(stall), 64'h0);
    issue("post_rst_mult", 6'h19, 32'd5, 32'd9, 32'd0, 32'd45, 1'b1, acc2);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and HI/LO width (legal: 8..64, even).
REQ-002 SHALL have parameter ALUOP_W, default 3, width of ALUOp_i.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  instruction present in decode this cycle.
REQ-006 SHALL have port funct_i  input  6  R-type function field.
REQ-007 SHALL have port ALUOp_i  input  ALUOP_W  main-control ALU operation class.
REQ-008 SHALL have port src1_i / src2_i  input  WIDTH each  rs / rt operand values.
REQ-009 SHALL have port ALUCtrl_o  output  4  ALU operation select (combinational).
REQ-010 SHALL have port stall_o  output  1  pipeline hold request (combinational).
REQ-011 SHALL have port hi_o / lo_o  output  WIDTH each  registered HI/LO contents.
REQ-012 SHALL have port mdu_done_o  output  1  registered one-cycle pulse on HI/LO update.

Function
REQ-013 ALUCtrl_o SHALL decode ALUOp_i: 000 add 0010; 001 sub 0110; 011 add 0010; 100 slt 0111; 101 and 0000; 110 or 0001; 111 and others 0000.
REQ-014 For ALUOp_i=010, funct_i SHALL map: 100000 0010; 100010 0110; 100100 0000; 100101 0001; 101010 0111; 100111 nor 1100; 010000 mfhi 1110; 010010 mflo 1111; 011000-011011 0000; other 0000.
REQ-015 MDU ops (ALUOp_i=010): mult 011000, multu 011001, div 011010, divu 011011.
REQ-016 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE->BUSY when valid_i=1 and funct_i is an MDU op; operands, op and signedness latched at that edge (accept edge); counter loaded WIDTH-1.
REQ-018 BUSY: one iteration per cycle (shift-add multiply / restoring divide on magnitudes), counter decrements; at the edge counter=0, BUSY->DONE and HI/LO written at the same edge.
REQ-019 DONE: mdu_done_o=1 for exactly that cycle; DONE->IDLE next edge; an MDU op presented in DONE is accepted (DONE->BUSY) with no bubble.
REQ-020 Latency: HI/LO hold the new result WIDTH cycles after the accept edge.
REQ-021 Multiply: {HI,LO} = full 2*WIDTH-bit product; signed when mult, product negated iff operand signs differ.
REQ-022 Divide: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-023 Divide by zero: still WIDTH cycles; LO=all ones, HI=dividend; no exception signalled.
REQ-024 Signed most-negative / -1: LO=most-negative value, HI=0.
REQ-025 stall_o=1 when valid_i=1 and state=BUSY and funct_i (ALUOp_i=010) is an MDU op, mfhi or mflo; otherwise 0; a stalled MDU op SHALL NOT be accepted until the FSM leaves BUSY.
REQ-026 mfhi/mflo in IDLE or DONE SHALL NOT stall; in DONE hi_o/lo_o already show the new result.
REQ-027 Non-MDU instructions never stall and never disturb FSM, HI or LO.
REQ-028 ALUCtrl_o SHALL ignore FSM state and be purely a function of ALUOp_i, funct_i.

Reset
REQ-029 rst_i=1 at an edge SHALL force state IDLE, counter 0, hi_o=0, lo_o=0, mdu_done_o=0; rst_i has priority over accept.
REQ-030 Reset during BUSY SHALL abort the operation with no HI/LO write and no done pulse.

Verification
REQ-031 WIDTH=32: mult src1=0xFFFFFFFF(-1), src2=3 -> after 32 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFD, done one cycle; multu same -> HI=0x00000002, LO=0xFFFFFFFD.
REQ-032 div src1=-7, src2=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 mflo issued 5 cycles after mult accept -> stall_o=1 until DONE cycle, then 0 with lo_o valid; ALUCtrl_o=1111 throughout.
REQ-034 Back-to-back: mult then div presented in DONE cycle -> div accepted that edge, second done pulse exactly 32 cycles later.
REQ-035 rst_i pulsed 10 cycles into div -> next cycle state IDLE, hi_o=lo_o=0, no mdu_done_o pulse; new mult accepted immediately after.
REQ-036 Sweep all ALUOp_i values and listed funct_i codes -> ALUCtrl_o matches REQ-013/014 table, including defaults 0000.
